// File: rtl/downcounter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | downcounter_pkg: shared state encoding and default sizing for the timer     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package downcounter_pkg;

  localparam int c_DEFAULT_WIDTH    = 8;
  localparam int c_DEFAULT_PRESCALE = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

endpackage : downcounter_pkg
`default_nettype wire

// File: rtl/downcounter_timer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | downcounter_timer_if: control/status bundle between a controller and timer  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface downcounter_timer_if
  import downcounter_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH
);

  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             enable;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             zero;
  logic             done;
  logic             busy;

  modport master (
    output load, load_value, enable, auto_reload,
    input  count, zero, done, busy
  );

  modport slave (
    input  load, load_value, enable, auto_reload,
    output count, zero, done, busy
  );

endinterface : downcounter_timer_if
`default_nettype wire

// File: rtl/downcounter_prescaler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | downcounter_prescaler: emits tick on every PRESCALE-th advanced cycle       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module downcounter_prescaler
  import downcounter_pkg::*;
#(
  parameter int PRESCALE = c_DEFAULT_PRESCALE
) (
  input  wire logic clock,
  input  wire logic reset,
  input  wire logic clear,
  input  wire logic advance,
  output logic      tick
);

  localparam int c_PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [c_PW-1:0] c_LAST = c_PW'(PRESCALE - 1);

  logic [c_PW-1:0] r_cnt;
  logic            w_last;

  assign w_last = (r_cnt == c_LAST);
  // Combinational so the decrement lands on the same edge the phase wraps.
  assign tick   = advance && w_last;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_cnt <= '0;
    end else if (advance) begin
      r_cnt <= w_last ? '0 : r_cnt + c_PW'(1);
    end
  end

endmodule : downcounter_prescaler
`default_nettype wire

// File: rtl/downcounter_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | downcounter_timer: loadable one-shot/periodic down-counting interval timer  |
// | Optional macro DOWNCOUNTER_PRESCALE_EN: decrement every PRESCALE cycles.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module downcounter_timer
  import downcounter_pkg::*;
#(
  parameter int WIDTH    = c_DEFAULT_WIDTH,
  parameter int PRESCALE = c_DEFAULT_PRESCALE
) (
  input wire logic            clock,
  input wire logic            reset,
  downcounter_timer_if.slave  bus
);

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_zero;
  logic             r_done;
  logic             r_busy;

  logic             w_active;
  logic             w_tick;
  logic             w_terminal;

  if (PRESCALE < 2) begin : g_prescale_check
    $error("downcounter_timer: PRESCALE must be >= 2");
  end

  assign w_active   = (r_state != IDLE);
  assign w_terminal = (r_count == WIDTH'(1));

`ifdef DOWNCOUNTER_PRESCALE_EN
  downcounter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clock   (clock),
    .reset   (reset),
    .clear   (bus.load),
    .advance (bus.enable && w_active),
    .tick    (w_tick)
  );
`else
  assign w_tick = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_reload <= '0;
      r_zero   <= 1'b1;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else if (bus.load) begin
      // A load always wins over a terminal event and suppresses its done pulse.
      r_count  <= bus.load_value;
      r_reload <= bus.load_value;
      r_done   <= 1'b0;
      if (bus.load_value == '0) begin
        r_state <= IDLE;
        r_zero  <= 1'b1;
        r_busy  <= 1'b0;
      end else begin
        r_state <= bus.enable ? RUN : PAUSE;
        r_zero  <= 1'b0;
        r_busy  <= 1'b1;
      end
    end else begin
      r_done <= 1'b0;
      if (w_active) begin
        if (!bus.enable) begin
          r_state <= PAUSE;
        end else begin
          r_state <= RUN;
          if (w_tick) begin
            if (w_terminal) begin
              r_done <= 1'b1;
              // Periodic mode jumps straight back to the period, never showing 0.
              if (bus.auto_reload && (r_reload != '0)) begin
                r_count <= r_reload;
              end else begin
                r_count <= '0;
                r_zero  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= IDLE;
              end
            end else begin
              r_count <= r_count - WIDTH'(1);
            end
          end
        end
      end
    end
  end

  assign bus.count = r_count;
  assign bus.zero  = r_zero;
  assign bus.done  = r_done;
  assign bus.busy  = r_busy;

endmodule : downcounter_timer
`default_nettype wire

// File: doc/downcounter_timer.md
Name: downcounter_timer

Overview:
- Synchronous, loadable down-counter used as a one-shot or periodic interval timer.
- Software or a controlling FSM loads a start value, gates counting with enable, and receives a single-cycle done pulse at terminal count.
- It is the counting-down counterpart of the free-running up counter used elsewhere in the design.
- It never wraps: it stops at zero or reloads, so downstream logic sees a clean expiry event.

Parameters:
- WIDTH, 8: width of count, load_value and the internal reload register.
- PRESCALE, 4: clock cycles per decrement. Used only when DOWNCOUNTER_PRESCALE_EN is defined; must be >= 2.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- load  input  1  capture load_value into count and the reload register.
- load_value  input  WIDTH  start/period value.
- enable  input  1  count permission.
- auto_reload  input  1  periodic mode when high at the terminal edge.
- count  output  WIDTH  current counter value (registered).
- zero  output  1  registered; high when count == 0.
- done  output  1  one-cycle pulse on expiry.
- busy  output  1  high in RUN or PAUSE.

Behaviour:
- Reset: reset is synchronous and active-high; clock is the only clock. On reset, count=0, zero=1, done=0, busy=0, reload register=0, state=IDLE. Reset overrides load, enable and terminal events on the same edge, including mid-count.
- States: IDLE, RUN, PAUSE. busy=1 in RUN and PAUSE. All outputs are registered.
- Load (highest priority after reset, accepted in any state):
  - count<=load_value and reload<=load_value.
  - Next state is IDLE if load_value==0, else RUN if enable=1, else PAUSE.
  - done=0 on a load edge, even if a terminal event would otherwise occur.
  - First decrement happens on the edge after the load edge (1-cycle load latency).
- RUN:
  - enable=1: count<=count-1.
  - enable=0: no decrement; go to PAUSE.
- PAUSE:
  - enable=0: hold count.
  - enable=1: decrement on that edge and go to RUN.
- Terminal edge (decrement with count==1):
  - done<=1 for exactly one cycle.
  - auto_reload=0: count<=0, state to IDLE, busy<=0 on the same edge.
  - auto_reload=1 and reload!=0: count<=reload, stay in RUN. count never shows 0, zero stays 0, and done repeats every reload enabled cycles.
  - auto_reload is sampled only at the terminal edge.
- IDLE:
  - enable is ignored; count holds 0 and never wraps to 2^WIDTH-1.
  - done is never generated from IDLE.
- Arithmetic: WIDTH-bit unsigned. A loaded value of 2^WIDTH-1 counts down fully with no overflow handling.

Optional Feature:
- Macro: DOWNCOUNTER_PRESCALE_EN.
- Defined:
  - An internal prescale counter advances on enabled RUN/PAUSE cycles.
  - A decrement occurs only on the enabled edge where the prescale counter equals PRESCALE-1; the prescale counter then returns to 0.
  - The prescale counter clears on reset and load, and holds while enable=0.
  - Expiry time = value*PRESCALE enabled cycles.
- Undefined: decrement on every enabled cycle; the PRESCALE parameter has no effect.

Decomposition:
- Package downcounter_pkg holds:
  - the state enum typedef (IDLE, RUN, PAUSE);
  - the default width constant;
  - the default prescale constant.
- Sub-module downcounter_prescaler (tick generator with enable/clear) is instantiated only under DOWNCOUNTER_PRESCALE_EN.
- The main FSM and datapath stay in downcounter_timer.

Test Plan (WIDTH=8, macro undefined unless stated):
1. Reset for 2 cycles, then release -> count=0, zero=1, done=0, busy=0; enable=1 for 5 cycles -> count stays 0 (no wrap to 255).
2. load=1 with load_value=5, enable=1 held, auto_reload=0 -> count 5,4,3,2,1,0 on successive edges; done=1 only in the cycle count=0; busy falls on that same edge; state IDLE afterwards.
3. auto_reload=1, load 3, enable=1 -> count 3,2,1,3,2,1,...; done pulses every 3 cycles; zero never asserted.
4. Load 6, enable drops for 2 cycles at count=4 -> count holds 4, busy=1 (PAUSE); on re-enable -> 3,2,1,0 and done.
5. Load 7 on the edge where count would go 1->0 -> count=7, done=0, state RUN; reset asserted at count=3 -> next edge count=0, zero=1, busy=0, no done.
6. DOWNCOUNTER_PRESCALE_EN defined, PRESCALE=4, load 2, enable=1 -> count changes every 4 cycles; done at cycle 8 after load.
